// File: rtl/decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_pkg                                                           |
// | Opcodes, instruction field positions and register-file sizing for    |
// | the 16-bit decode stage.                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package decode_pkg;

    localparam int NREG      = 8;
    localparam int REG_IDX_W = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [2:0]           opcode_t;

    localparam opcode_t OP_LUI = 3'b011;
    localparam opcode_t OP_SW  = 3'b100;
    localparam opcode_t OP_LW  = 3'b101;
    localparam opcode_t OP_BR  = 3'b110;
    localparam opcode_t OP_SYS = 3'b111;

    localparam int OPC_LSB   = 13;
    localparam int RA_LSB    = 10;
    localparam int RB_LSB    = 7;
    localparam int RC_LSB    = 0;
    localparam int ALU_LSB   = 3;
    localparam int ALU_W     = 4;
    localparam int BR_LSB    = 7;
    localparam int BR_W      = 6;
    localparam int IMM7_W    = 7;
    localparam int IMM10_W   = 10;
    localparam int LUI_SHIFT = 6;

    function automatic reg_idx_t field_idx(input logic [15:0] instr, input int lsb);
        return instr[lsb +: REG_IDX_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_regfile                                                       |
// | NREG x XLEN register file, two combinational read ports, one write   |
// | port; r0 always reads zero.                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module decode_regfile
    import decode_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  reg_idx_t        waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  reg_idx_t        raddr1_i,
    input  reg_idx_t        raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NREG];

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule
`default_nettype wire

// File: rtl/decode_stage_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_stage_param                                                   |
// | Decode stage: field decode, immediates, register file, multi-entry   |
// | load-use scoreboard and halt detection. Optional macro               |
// | DECODE_WB_BYPASS_EN forwards same-cycle writeback into operands.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module decode_stage_param
    import decode_pkg::*;
#(
    parameter int XLEN     = 16,
    parameter int PC_W     = 16,
    parameter int LOAD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [15:0]     instr_in,
    input  logic            valid_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic            wb_we,
    input  logic [2:0]      wb_tgt,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            valid_out,
    output logic [2:0]      opcode_out,
    output logic [2:0]      s_1_out,
    output logic [2:0]      s_2_out,
    output logic [2:0]      tgt_out,
    output logic [3:0]      alu_op_out,
    output logic [5:0]      branch_code_out,
    output logic [XLEN-1:0] imm_out,
    output logic [XLEN-1:0] d_1_out,
    output logic [XLEN-1:0] d_2_out,
    output logic [PC_W-1:0] pc_out,
    output logic            halt_out
);

    opcode_t         opcode;
    reg_idx_t        ra, rb, rc, s1, s2;
    logic [XLEN-1:0] imm_d, rd1, rd2, d1_d, d2_d;
    logic            hazard, issue, halt_d;
    reg_idx_t        tgt_d, sb_in_d;
    reg_idx_t        sb_q [LOAD_LAT];

    assign opcode = instr_in[OPC_LSB +: 3];
    assign ra     = field_idx(instr_in, RA_LSB);
    assign rb     = field_idx(instr_in, RB_LSB);
    assign rc     = field_idx(instr_in, RC_LSB);
    assign s1     = rb;
    assign s2     = (opcode == OP_SW) ? ra : rc;

    always_comb begin
        if (opcode == OP_LUI) begin
            imm_d = XLEN'({instr_in[IMM10_W-1:0], {LUI_SHIFT{1'b0}}});
        end else begin
            imm_d = XLEN'($signed(instr_in[IMM7_W-1:0]));
        end
    end

    // Both sources are compared whatever the opcode; conservative by design.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if ((sb_q[i] != '0) && ((sb_q[i] == s1) || (sb_q[i] == s2))) begin
                hazard = 1'b1;
            end
        end
    end

    assign stall   = valid_in && hazard && !flush;
    assign issue   = valid_in && !flush && !stall;
    assign sb_in_d = (issue && (opcode == OP_LW) && (ra != '0)) ? ra : '0;
    assign tgt_d   = (!issue || (opcode == OP_SW) || (opcode == OP_BR)) ? '0 : ra;
    assign halt_d  = issue && (opcode == OP_SYS) && (instr_in[IMM7_W-1:0] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            sb_q[0] <= sb_in_d;
            for (int i = 1; i < LOAD_LAT; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    decode_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (wb_we),
        .waddr_i  (wb_tgt),
        .wdata_i  (wb_data),
        .raddr1_i (s1),
        .raddr2_i (s2),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

`ifdef DECODE_WB_BYPASS_EN
    assign d1_d = (wb_we && (wb_tgt != '0) && (wb_tgt == s1)) ? wb_data : rd1;
    assign d2_d = (wb_we && (wb_tgt != '0) && (wb_tgt == s2)) ? wb_data : rd2;
`else
    assign d1_d = rd1;
    assign d2_d = rd2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out       <= 1'b0;
            opcode_out      <= '0;
            s_1_out         <= '0;
            s_2_out         <= '0;
            tgt_out         <= '0;
            alu_op_out      <= '0;
            branch_code_out <= '0;
            imm_out         <= '0;
            d_1_out         <= '0;
            d_2_out         <= '0;
            pc_out          <= '0;
            halt_out        <= 1'b0;
        end else begin
            valid_out       <= issue;
            opcode_out      <= opcode;
            s_1_out         <= s1;
            s_2_out         <= s2;
            tgt_out         <= tgt_d;
            alu_op_out      <= instr_in[ALU_LSB +: ALU_W];
            branch_code_out <= instr_in[BR_LSB +: BR_W];
            imm_out         <= imm_d;
            d_1_out         <= d1_d;
            d_2_out         <= d2_d;
            pc_out          <= pc_in;
            halt_out        <= halt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_decode_stage_param                                                |
// | Randomised and directed stimulus against a timestamp-based model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_decode_stage_param;

    localparam int XLEN = 32;
    localparam int PC_W = 16;
    localparam int LAT  = 2;

    logic            clk = 1'b0;
    logic            rst_n, flush, valid_in, wb_we;
    logic [15:0]     instr_in;
    logic [PC_W-1:0] pc_in;
    logic [2:0]      wb_tgt;
    logic [XLEN-1:0] wb_data;
    logic            stall, valid_out, halt_out;
    logic [2:0]      opcode_out, s_1_out, s_2_out, tgt_out;
    logic [3:0]      alu_op_out;
    logic [5:0]      branch_code_out;
    logic [XLEN-1:0] imm_out, d_1_out, d_2_out;
    logic [PC_W-1:0] pc_out;

    always #5 clk = ~clk;

    decode_stage_param #(
        .XLEN     (XLEN),
        .PC_W     (PC_W),
        .LOAD_LAT (LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .instr_in        (instr_in),
        .valid_in        (valid_in),
        .pc_in           (pc_in),
        .wb_we           (wb_we),
        .wb_tgt          (wb_tgt),
        .wb_data         (wb_data),
        .stall           (stall),
        .valid_out       (valid_out),
        .opcode_out      (opcode_out),
        .s_1_out         (s_1_out),
        .s_2_out         (s_2_out),
        .tgt_out         (tgt_out),
        .alu_op_out      (alu_op_out),
        .branch_code_out (branch_code_out),
        .imm_out         (imm_out),
        .d_1_out         (d_1_out),
        .d_2_out         (d_2_out),
        .pc_out          (pc_out),
        .halt_out        (halt_out)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: register values, and per register the first cycle its loaded value is usable.
    logic [XLEN-1:0] m_regs  [8];
    longint          m_ready [8];
    longint          m_cycle = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_regs[i]  = '0;
            m_ready[i] = 0;
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] ra,
                                       input logic [2:0] rb, input logic [6:0] lo);
        return {op, ra, rb, lo};
    endfunction

    task automatic step(input logic [15:0] ins, input logic v, input logic fl,
                        input logic [PC_W-1:0] pc, input logic we, input logic [2:0] wt,
                        input logic [XLEN-1:0] wd, output logic st);
        logic [2:0]      op, ra, rb, rc, s1, s2, e_tgt;
        logic            e_stall, iss;
        logic [XLEN-1:0] e_imm, e_d1, e_d2;
        int              v7;
        @(negedge clk);
        instr_in = ins; valid_in = v; flush = fl; pc_in = pc;
        wb_we = we; wb_tgt = wt; wb_data = wd;
        #1;
        op = ins[15:13]; ra = ins[12:10]; rb = ins[9:7]; rc = ins[2:0];
        s1 = rb;
        s2 = (op == 3'd4) ? ra : rc;
        e_stall = v && !fl && ((s1 != 0 && m_cycle < m_ready[s1]) ||
                               (s2 != 0 && m_cycle < m_ready[s2]));
        check_eq("stall", stall, e_stall);
        st  = stall;
        iss = v && !fl && !e_stall;
        if (op == 3'd3) begin
            e_imm = XLEN'(int'(ins[9:0]) * 64);
        end else begin
            v7 = int'(ins[6:0]);
            if (v7 >= 64) v7 -= 128;
            e_imm = XLEN'(v7);
        end
        e_d1 = m_regs[s1];
        e_d2 = m_regs[s2];
`ifdef DECODE_WB_BYPASS_EN
        if (we && wt != 0 && wt == s1) e_d1 = wd;
        if (we && wt != 0 && wt == s2) e_d2 = wd;
`endif
        e_tgt = (!iss || op == 3'd4 || op == 3'd6) ? 3'd0 : ra;
        @(posedge clk);
        #1;
        check_eq("valid_out", valid_out, iss);
        check_eq("opcode_out", opcode_out, op);
        check_eq("s_1_out", s_1_out, s1);
        check_eq("s_2_out", s_2_out, s2);
        check_eq("tgt_out", tgt_out, e_tgt);
        check_eq("alu_op_out", alu_op_out, ins[6:3]);
        check_eq("branch_code_out", branch_code_out, ins[12:7]);
        check_eq("imm_out", imm_out, e_imm);
        check_eq("d_1_out", d_1_out, e_d1);
        check_eq("d_2_out", d_2_out, e_d2);
        check_eq("pc_out", pc_out, pc);
        check_eq("halt_out", halt_out, iss && op == 3'd7 && ins[6:0] != 0);
        if (we && wt != 0) m_regs[wt] = wd;
        if (iss && op == 3'd5 && ra != 0) m_ready[ra] = m_cycle + LAT + 1;
        m_cycle++;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_stall"}, stall, 0);
        check_eq({tag, "_valid"}, valid_out, 0);
        check_eq({tag, "_opcode"}, opcode_out, 0);
        check_eq({tag, "_s1"}, s_1_out, 0);
        check_eq({tag, "_s2"}, s_2_out, 0);
        check_eq({tag, "_tgt"}, tgt_out, 0);
        check_eq({tag, "_alu"}, alu_op_out, 0);
        check_eq({tag, "_br"}, branch_code_out, 0);
        check_eq({tag, "_imm"}, imm_out, 0);
        check_eq({tag, "_d1"}, d_1_out, 0);
        check_eq({tag, "_d2"}, d_2_out, 0);
        check_eq({tag, "_pc"}, pc_out, 0);
        check_eq({tag, "_halt"}, halt_out, 0);
    endtask

    task automatic random_phase(input int n);
        logic [15:0]     ins = '0;
        logic            v = 1'b0, st = 1'b0;
        logic [PC_W-1:0] pc = '0;
        int              k;
        for (int i = 0; i < n; i++) begin
            if (!st) begin
                k   = $urandom_range(0, 10);
                ins = {(k >= 8) ? 3'd5 : 3'(k), 13'($urandom)};
                v   = ($urandom_range(0, 6) != 0);
                pc  = PC_W'($urandom);
            end
            step(ins, v, ($urandom_range(0, 9) == 0), pc, 1'($urandom),
                 3'($urandom), XLEN'($urandom), st);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st;
        int   nst;
        rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; wb_we = 1'b0;
        instr_in = '0; pc_in = '0; wb_tgt = '0; wb_data = '0;
        model_clear();
        #2;
        check_outputs_zero("rst_init");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back load-use: lw r3 ; add r4,r3,r1
        step(mk(3'd5, 3'd3, 3'd0, 7'd0), 1, 0, 16'h0100, 0, 0, 0, st);
        nst = 0;
        for (int i = 0; i < 6; i++) begin
            step(mk(3'd0, 3'd4, 3'd3, 7'd1), 1, 0, 16'h0102, 0, 0, 0, st);
            if (!st) break;
            nst++;
        end
        check_eq("loaduse_stall_cycles", nst, LAT);
        check_eq("loaduse_issue_s1", s_1_out, 3);
        check_eq("loaduse_issue_valid", valid_out, 1);

        // Independent loads never stall
        step(mk(3'd5, 3'd0, 3'd0, 7'd0), 1, 0, 16'h0200, 0, 0, 0, st);
        check_eq("indep_lw_r0_stall", st, 0);
        step(mk(3'd5, 3'd2, 3'd0, 7'd0), 1, 0, 16'h0202, 0, 0, 0, st);
        check_eq("indep_lw_r2_stall", st, 0);
        step(mk(3'd0, 3'd5, 3'd6, 7'd7), 1, 0, 16'h0204, 0, 0, 0, st);
        check_eq("indep_add_stall", st, 0);

        // Flush over a hazard: killed lw r5 must not enter the scoreboard; r3 entry survives
        repeat (3) step(16'h0, 0, 0, 16'h0, 0, 0, 0, st);
        step(mk(3'd5, 3'd3, 3'd0, 7'd0), 1, 0, 16'h0300, 0, 0, 0, st);
        step(mk(3'd5, 3'd5, 3'd3, 7'd0), 1, 1, 16'h0302, 0, 0, 0, st);
        check_eq("flush_stall", st, 0);
        check_eq("flush_valid_out", valid_out, 0);
        check_eq("flush_tgt_out", tgt_out, 0);
        nst = 0;
        for (int i = 0; i < 6; i++) begin
            step(mk(3'd0, 3'd4, 3'd5, 7'd3), 1, 0, 16'h0304, 0, 0, 0, st);
            if (!st) break;
            nst++;
        end
        check_eq("flush_retained_stalls", nst, 1);

        // Immediates and halt
        step(mk(3'd1, 3'd1, 3'd0, 7'h7F), 1, 0, 16'h0400, 0, 0, 0, st);
        check_eq("imm_addi", imm_out, 32'hFFFF_FFFF);
        step(16'h67FF, 1, 0, 16'h0402, 0, 0, 0, st);
        check_eq("imm_lui", imm_out, 32'h0000_FFC0);
        step(mk(3'd7, 3'd0, 3'd0, 7'd1), 1, 0, 16'h0404, 0, 0, 0, st);
        check_eq("halt_valid", halt_out, 1);
        step(mk(3'd7, 3'd0, 3'd0, 7'd1), 0, 0, 16'h0406, 0, 0, 0, st);
        check_eq("halt_bubble", halt_out, 0);

        // Same-cycle writeback vs read of r2
        step(16'h0, 0, 0, 16'h0, 1, 3'd2, 32'h0000_1234, st);
        step(mk(3'd0, 3'd1, 3'd2, 7'd0), 1, 0, 16'h0500, 1, 3'd2, 32'h0000_BEEF, st);
`ifdef DECODE_WB_BYPASS_EN
        check_eq("bypass_d1", d_1_out, 32'h0000_BEEF);
`else
        check_eq("bypass_d1", d_1_out, 32'h0000_1234);
`endif

        random_phase(300);

        // Reset in the middle of a load-use stall
        repeat (3) step(16'h0, 0, 0, 16'h0, 0, 0, 0, st);
        step(mk(3'd5, 3'd3, 3'd0, 7'd0), 1, 0, 16'h0600, 0, 0, 0, st);
        @(negedge clk);
        instr_in = mk(3'd0, 3'd4, 3'd3, 7'd1); valid_in = 1'b1;
        #1;
        check_eq("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        @(posedge clk);
        #1;
        check_outputs_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        valid_in = 1'b0;
        model_clear();
        for (int r = 1; r < 8; r++) begin
            step(mk(3'd0, 3'd0, 3'(r), {4'd0, 3'(r)}), 1, 0, 16'h0700, 0, 0, 0, st);
            check_eq("post_rst_reg_d1", d_1_out, 0);
            check_eq("post_rst_reg_d2", d_2_out, 0);
        end

        random_phase(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
